// File: rtl/logger_wr_ctrl.sv
// Write-side controller for the on-chip event log.
// Accepts one entry per cycle and writes it into a circular log RAM. It keeps
// the write pointer and wrap flag that the read side reports as metadata. It
// also provides a hardware clear sweep, a stop-on-wrap capture mode and a
// saturating count of entries that were dropped while the log was not accepting.
module logger_wr_ctrl #(
  parameter int LOG_ADDR_W = 13,
  parameter int LOG_DATA_W = 64,
  parameter int DROP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  log_en,
  input  logic                  log_clear,
  input  logic                  stop_on_wrap,
  input  logic                  entry_val,
  input  logic [LOG_DATA_W-1:0] entry_data,
  output logic                  log_wr_req_val,
  output logic [LOG_ADDR_W-1:0] log_wr_req_addr,
  output logic [LOG_DATA_W-1:0] log_wr_req_data,
  output logic [LOG_ADDR_W-1:0] curr_log_wr_addr,
  output logic                  has_wrapped,
  output logic                  halted,
  output logic                  clear_busy,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOGGING,
    S_HALTED,
    S_CLEARING
  } state_e;

  // The last RAM word. Reaching it is the only address compare in the design;
  // every other pointer step relies on modulo wrap-around.
  localparam logic [LOG_ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [DROP_CNT_W-1:0] DROP_MAX  = '1;

  state_e                  state_q, state_d;
  logic [LOG_ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic                    wrapped_q, wrapped_d;
  logic [DROP_CNT_W-1:0]   drop_q, drop_d;
  logic [LOG_ADDR_W-1:0]   sweep_q, sweep_d;
  logic                    drop_inc;
  logic                    sweep_done;

  // Next-state, pointer updates and the zero-latency RAM write request.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d         = state_q;
    wr_addr_d       = wr_addr_q;
    wrapped_d       = wrapped_q;
    sweep_d         = sweep_q;
    drop_inc        = 1'b0;
    sweep_done      = 1'b0;
    log_wr_req_val  = 1'b0;
    log_wr_req_addr = wr_addr_q;
    log_wr_req_data = entry_data;

    unique case (state_q)
      S_IDLE: begin
        // Entries arriving here are neither written nor counted as drops.
        if (log_en) state_d = S_LOGGING;
      end
      S_LOGGING: begin
        if (!log_en) begin
          state_d = S_IDLE;
        end else if (entry_val) begin
          log_wr_req_val = 1'b1;
          wr_addr_d      = wr_addr_q + LOG_ADDR_W'(1);
          if (wr_addr_q == ADDR_LAST) begin
            wrapped_d = 1'b1;
            // stop_on_wrap matters only on the wrapping write itself.
            if (stop_on_wrap) state_d = S_HALTED;
          end
        end
      end
      S_HALTED: begin
        drop_inc = entry_val;
      end
      S_CLEARING: begin
        log_wr_req_val  = 1'b1;
        log_wr_req_addr = sweep_q;
        log_wr_req_data = '0;
        sweep_d         = sweep_q + LOG_ADDR_W'(1);
        drop_inc        = entry_val;
        if (sweep_q == ADDR_LAST) begin
          state_d    = S_IDLE;
          wr_addr_d  = '0;
          wrapped_d  = 1'b0;
          sweep_done = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A clear request wins over everything. An entry presented on the request
    // cycle is dropped, but a sweep already in flight still writes this cycle.
    // The metadata is zeroed at once so readers see an empty log during the sweep.
    if (log_clear) begin
      state_d    = S_CLEARING;
      sweep_d    = '0;
      wr_addr_d  = '0;
      wrapped_d  = 1'b0;
      sweep_done = 1'b0;
      if (state_q != S_CLEARING) begin
        log_wr_req_val = 1'b0;
        drop_inc       = entry_val;
      end
    end
  end

  // The dropped-entry counter saturates. The end of a sweep zeroes it and
  // overrides a drop counted on that same cycle.
  always_comb begin
    drop_d = drop_q;
    if (sweep_done)                        drop_d = '0;
    else if (drop_inc && drop_q != DROP_MAX) drop_d = drop_q + DROP_CNT_W'(1);
  end

  // State and pointer registers. The RAM itself lives outside this block, and
  // reset leaves its contents untouched.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values from before the edge.
    if (rst) begin
      state_q   <= S_IDLE;
      wr_addr_q <= '0;
      wrapped_q <= 1'b0;
      drop_q    <= '0;
      sweep_q   <= '0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      wrapped_q <= wrapped_d;
      drop_q    <= drop_d;
      sweep_q   <= sweep_d;
    end
  end

  assign curr_log_wr_addr = wr_addr_q;
  assign has_wrapped      = wrapped_q;
  assign halted           = (state_q == S_HALTED);
  assign clear_busy       = (state_q == S_CLEARING);
  assign drop_cnt         = drop_q;

endmodule

// File: tb/tb_logger_wr_ctrl.sv
// Self-checking bench for logger_wr_ctrl with an 8-deep log and a 4-bit drop
// counter. A cycle-level behavioural model of the log, built from plain
// counters and an array, predicts every output.
module tb_logger_wr_ctrl;

  localparam int AW    = 3;
  localparam int DW    = 64;
  localparam int CW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          log_en = 1'b0, log_clear = 1'b0, stop_on_wrap = 1'b0, entry_val = 1'b0;
  logic [DW-1:0] entry_data = '0;
  logic          log_wr_req_val;
  logic [AW-1:0] log_wr_req_addr;
  logic [DW-1:0] log_wr_req_data;
  logic [AW-1:0] curr_log_wr_addr;
  logic          has_wrapped, halted, clear_busy;
  logic [CW-1:0] drop_cnt;

  logger_wr_ctrl #(.LOG_ADDR_W(AW), .LOG_DATA_W(DW), .DROP_CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .log_en(log_en), .log_clear(log_clear),
    .stop_on_wrap(stop_on_wrap), .entry_val(entry_val), .entry_data(entry_data),
    .log_wr_req_val(log_wr_req_val), .log_wr_req_addr(log_wr_req_addr),
    .log_wr_req_data(log_wr_req_data), .curr_log_wr_addr(curr_log_wr_addr),
    .has_wrapped(has_wrapped), .halted(halted), .clear_busy(clear_busy),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Everything observable in one cycle. Write address/data are zeroed when no
  // write is requested, since they carry no meaning then.
  typedef struct packed {
    logic          val;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [AW-1:0] curr;
    logic          wrapped;
    logic          halt;
    logic          busy;
    logic [CW-1:0] drop;
  } outs_t;

  outs_t obs, exp;
  int    total = 0;
  int    bad   = 0;

  // Behavioural model: the log is "logging", "halted", or sweeping with a
  // number of cycles still to go; otherwise it is waiting to be enabled.
  bit            m_logging, m_halted;
  int            m_clear_left, m_ptr, m_drops;
  bit            m_wrapped;
  logic [DW-1:0] m_ram   [DEPTH];
  logic [DW-1:0] dut_ram [DEPTH];

  function automatic int sat_inc(input int v);
    return (v == CMAX) ? CMAX : v + 1;
  endfunction

  task automatic model_reset();
    m_logging = 0; m_halted = 0; m_clear_left = 0;
    m_ptr = 0; m_wrapped = 0; m_drops = 0;
  endtask

  // One clock cycle: drive inputs at the falling edge, sample everything 1ns
  // later, form the model prediction, then advance the model.
  task automatic run_cycle(input logic en, input logic clr, input logic sow,
                           input logic ev, input logic [DW-1:0] d);
    @(negedge clk);
    log_en = en; log_clear = clr; stop_on_wrap = sow; entry_val = ev; entry_data = d;
    #1;
    obs         = '0;
    obs.val     = log_wr_req_val;
    if (log_wr_req_val === 1'b1) begin
      obs.addr = log_wr_req_addr;
      obs.data = log_wr_req_data;
      dut_ram[log_wr_req_addr] = log_wr_req_data;
    end
    obs.curr    = curr_log_wr_addr;
    obs.wrapped = has_wrapped;
    obs.halt    = halted;
    obs.busy    = clear_busy;
    obs.drop    = drop_cnt;

    exp         = '0;
    exp.curr    = AW'(m_ptr);
    exp.wrapped = m_wrapped;
    exp.halt    = m_halted;
    exp.busy    = (m_clear_left > 0);
    exp.drop    = CW'(m_drops);
    if (m_clear_left > 0) begin
      exp.val  = 1'b1;
      exp.addr = AW'(DEPTH - m_clear_left);
      exp.data = '0;
      m_ram[DEPTH - m_clear_left] = '0;
    end else if (m_logging && en && ev && !clr) begin
      exp.val  = 1'b1;
      exp.addr = AW'(m_ptr);
      exp.data = d;
    end

    if (clr) begin
      if (ev) m_drops = sat_inc(m_drops);
      m_clear_left = DEPTH; m_ptr = 0; m_wrapped = 0;
      m_logging = 0; m_halted = 0;
    end else if (m_clear_left > 0) begin
      if (ev) m_drops = sat_inc(m_drops);
      m_clear_left--;
      if (m_clear_left == 0) begin
        m_ptr = 0; m_wrapped = 0; m_drops = 0;
      end
    end else if (m_halted) begin
      if (ev) m_drops = sat_inc(m_drops);
    end else if (m_logging) begin
      if (!en) m_logging = 0;
      else if (ev) begin
        m_ram[m_ptr] = d;
        if (m_ptr == DEPTH - 1) begin
          m_wrapped = 1;
          if (sow) begin m_halted = 1; m_logging = 0; end
        end
        m_ptr = (m_ptr + 1) % DEPTH;
      end
    end else if (en) begin
      m_logging = 1;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; log_en = 0; log_clear = 0; stop_on_wrap = 0; entry_val = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    run_cycle(0, 0, 0, 1, 64'h55);
    total++;
    if (obs !== outs_t'('0)) begin
      bad++; $display("FAIL reset_state: got=%h want=%h", obs, outs_t'('0));
    end
    total++;
    if (obs !== exp) begin bad++; $display("FAIL reset_model: got=%h want=%h", obs, exp); end
  endtask

  task automatic test_basic();
    apply_reset();
    run_cycle(1, 0, 0, 0, '0);
    for (int i = 0; i < 5; i++) begin
      run_cycle(1, 0, 0, 1, DW'(8'h10 + i));
      total++;
      if (obs !== exp) begin bad++; $display("FAIL basic_write%0d: got=%h want=%h", i, obs, exp); end
      total++;
      if (obs.val !== 1'b1 || obs.addr !== AW'(i) || obs.data !== DW'(8'h10 + i)) begin
        bad++; $display("FAIL basic_addr%0d: got val=%b addr=%0d data=%h", i, obs.val, obs.addr, obs.data);
      end
    end
    run_cycle(1, 0, 0, 0, '0);
    total++;
    if (obs.curr !== AW'(5) || obs.wrapped !== 1'b0) begin
      bad++; $display("FAIL basic_final: got curr=%0d wrapped=%b want 5/0", obs.curr, obs.wrapped);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    run_cycle(1, 0, 0, 0, '0);
    for (int i = 0; i < 10; i++) begin
      run_cycle(1, 0, 0, 1, DW'(8'hA0 + i));
      total++;
      if (obs !== exp) begin bad++; $display("FAIL wrap_cycle%0d: got=%h want=%h", i, obs, exp); end
      if (i == 8) begin
        total++;
        if (obs.addr !== AW'(0) || obs.wrapped !== 1'b1) begin
          bad++; $display("FAIL wrap_ninth: got addr=%0d wrapped=%b want 0/1", obs.addr, obs.wrapped);
        end
      end
    end
    run_cycle(1, 0, 0, 0, '0);
    total++;
    if (obs.curr !== AW'(2) || obs.wrapped !== 1'b1 || obs.halt !== 1'b0) begin
      bad++; $display("FAIL wrap_final: got curr=%0d wrapped=%b halted=%b want 2/1/0",
                      obs.curr, obs.wrapped, obs.halt);
    end
  endtask

  task automatic test_stop_on_wrap();
    apply_reset();
    run_cycle(1, 0, 1, 0, '0);
    for (int i = 0; i < 8; i++) begin
      run_cycle(1, 0, 1, 1, DW'($urandom()));
      total++;
      if (obs !== exp) begin bad++; $display("FAIL sow_write%0d: got=%h want=%h", i, obs, exp); end
    end
    for (int i = 0; i < 20; i++) begin
      run_cycle(1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)), 1, DW'($urandom()));
      if (i == 0) begin
        total++;
        if (obs.halt !== 1'b1 || obs.curr !== AW'(0)) begin
          bad++; $display("FAIL sow_halted: got halted=%b curr=%0d want 1/0", obs.halt, obs.curr);
        end
      end
      total++;
      if (obs !== exp) begin bad++; $display("FAIL sow_drop%0d: got=%h want=%h", i, obs, exp); end
    end
    run_cycle(0, 0, 0, 0, '0);
    total++;
    if (obs.drop !== CW'(CMAX) || obs.val !== 1'b0) begin
      bad++; $display("FAIL sow_saturate: got drop=%0d val=%b want %0d/0", obs.drop, obs.val, CMAX);
    end
  endtask

  // Starts from the halted state left by test_stop_on_wrap.
  task automatic test_clear();
    int busy_cycles = 0;
    int next_addr   = 0;
    run_cycle(0, 1, 0, 1'($urandom_range(0, 1)), '0);
    for (int i = 0; i < 12; i++) begin
      run_cycle(1'($urandom_range(0, 1)), 0, 0, 1'($urandom_range(0, 1)), DW'($urandom()));
      total++;
      if (obs !== exp) begin bad++; $display("FAIL clear_cycle%0d: got=%h want=%h", i, obs, exp); end
      if (obs.busy === 1'b1) begin
        busy_cycles++;
        total++;
        if (obs.val !== 1'b1 || obs.addr !== AW'(next_addr) || obs.data !== '0) begin
          bad++; $display("FAIL clear_order: got val=%b addr=%0d data=%h want addr %0d data 0",
                          obs.val, obs.addr, obs.data, next_addr);
        end
        next_addr++;
      end
    end
    total++;
    if (busy_cycles != DEPTH) begin
      bad++; $display("FAIL clear_len: got %0d busy cycles want %0d", busy_cycles, DEPTH);
    end
  endtask

  task automatic test_clear_restart();
    int busy_cycles = 0;
    int got_addrs[$];
    int want_addrs[$];
    want_addrs = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 6, 7};
    apply_reset();
    run_cycle(0, 1, 0, 0, '0);
    for (int k = 0; k < 14; k++) begin
      run_cycle(0, (k == 2), 0, 1'($urandom_range(0, 1)), '0);
      total++;
      if (obs !== exp) begin bad++; $display("FAIL restart_cycle%0d: got=%h want=%h", k, obs, exp); end
      if (obs.busy === 1'b1) busy_cycles++;
      if (obs.val === 1'b1) got_addrs.push_back(int'(obs.addr));
    end
    total++;
    if (busy_cycles != 11 || got_addrs != want_addrs) begin
      bad++; $display("FAIL restart_seq: got busy=%0d writes=%p want busy=11 writes=%p",
                      busy_cycles, got_addrs, want_addrs);
    end
  endtask

  task automatic test_enable_gating();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      run_cycle(0, 0, 0, 1, DW'($urandom()));
      total++;
      if (obs.val !== 1'b0 || obs.drop !== '0 || obs !== exp) begin
        bad++; $display("FAIL gate_idle%0d: got=%h want=%h", i, obs, exp);
      end
    end
    run_cycle(1, 0, 0, 0, '0);
    run_cycle(1, 0, 0, 1, 64'hBEEF);
    run_cycle(0, 0, 0, 1, 64'hDEAD);
    total++;
    if (obs.val !== 1'b0 || obs !== exp) begin
      bad++; $display("FAIL gate_fall: got=%h want=%h", obs, exp);
    end
    run_cycle(0, 0, 0, 1, 64'hDEAD);
    total++;
    if (obs.drop !== '0 || obs.curr !== AW'(1) || obs !== exp) begin
      bad++; $display("FAIL gate_after: got=%h want=%h", obs, exp);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 800; i++) begin
      if (i == 400) apply_reset();
      run_cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 59) == 0),
                1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7),
                {$urandom(), $urandom()});
      total++;
      if (obs !== exp) begin bad++; $display("FAIL random_cycle%0d: got=%h want=%h", i, obs, exp); end
    end
    for (int a = 0; a < DEPTH; a++) begin
      total++;
      if (dut_ram[a] !== m_ram[a]) begin
        bad++; $display("FAIL ram_word%0d: got=%h want=%h", a, dut_ram[a], m_ram[a]);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++) begin
      m_ram[a]   = '0;
      dut_ram[a] = '0;
    end
    model_reset();
    test_reset();
    test_basic();
    test_wrap();
    test_stop_on_wrap();
    test_clear();
    test_clear_restart();
    test_enable_gating();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/logger_wr_ctrl.md
Name: logger_wr_ctrl

Overview:
Write-side controller for the on-chip event log. It accepts one log entry per cycle from the instrumented datapath and writes it into the circular log RAM. It maintains the write pointer and wrap flag that the read-side command mux returns as metadata. It also supports a hardware clear sweep, a stop-on-wrap capture mode, and a saturating count of entries dropped while the log cannot accept them.

Parameters:
LOG_ADDR_W, 13, log RAM address width; depth = 2^LOG_ADDR_W entries
LOG_DATA_W, 64, log entry / RAM word width
DROP_CNT_W, 16, width of saturating dropped-entry counter

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
log_en  in  1  level; logging enabled while high
log_clear  in  1  single-cycle pulse; start clear sweep
stop_on_wrap  in  1  level; 1 = halt after last RAM word is written, 0 = overwrite circularly
entry_val  in  1  log entry present this cycle; no backpressure
entry_data  in  LOG_DATA_W  log entry payload
log_wr_req_val  out  1  RAM write strobe; RAM accepts every cycle
log_wr_req_addr  out  LOG_ADDR_W  RAM write address
log_wr_req_data  out  LOG_DATA_W  RAM write data
curr_log_wr_addr  out  LOG_ADDR_W  next address to be written
has_wrapped  out  1  pointer has wrapped at least once since the last clear/reset
halted  out  1  state == HALTED
clear_busy  out  1  state == CLEARING
drop_cnt  out  DROP_CNT_W  entries dropped, saturating

Behaviour:
- Reset values: state IDLE; curr_log_wr_addr 0; has_wrapped 0; drop_cnt 0; clear sweep pointer 0.
- Resulting reset outputs: log_wr_req_val 0, halted 0, clear_busy 0.
- Write outputs are combinational from state and inputs, with zero latency. Pointer and flag updates are visible the cycle after the write.
- States:
  - IDLE:
    - log_clear -> CLEARING.
    - else log_en -> LOGGING.
    - entry_val is ignored and not counted.
  - LOGGING:
    - entry_val && log_en: issue write at curr_log_wr_addr with entry_data, then increment the pointer.
    - Pointer at 2^LOG_ADDR_W-1: next value is 0 and has_wrapped <= 1.
    - If stop_on_wrap is also high on that write -> HALTED.
    - log_en low (without log_clear) -> IDLE. An entry_val in that same cycle is ignored and not counted.
  - HALTED:
    - No writes.
    - Each entry_val cycle increments drop_cnt, regardless of log_en.
    - Exit only via log_clear.
    - log_en and stop_on_wrap changes are ignored.
  - CLEARING:
    - Each cycle writes 0 to the sweep pointer address, then increments the sweep pointer.
    - The sweep takes exactly 2^LOG_ADDR_W cycles.
    - On the last address: sweep pointer <= 0, curr_log_wr_addr <= 0, has_wrapped <= 0, drop_cnt <= 0, and the next state is IDLE.
    - entry_val during CLEARING increments drop_cnt, but the final-cycle reset of drop_cnt overrides it.
    - log_clear during CLEARING restarts the sweep at address 0.
- log_clear priority:
  - log_clear has priority over everything in every state.
  - On a log_clear cycle outside CLEARING, no entry write occurs; entry_val on that cycle counts as a drop.
  - Next state is CLEARING with sweep pointer 0.
  - curr_log_wr_addr and has_wrapped are zeroed at clear start, so metadata readers see an empty log during the sweep.
- drop_cnt saturates at 2^DROP_CNT_W-1 and holds.
- stop_on_wrap is sampled only on the wrapping write. Raising it after a wrap has already occurred does not halt until the next wrap.
- Address arithmetic is modulo 2^LOG_ADDR_W, with no explicit compare beyond the wrap-detect at all-ones.
- Reset mid-sweep or mid-logging aborts immediately to reset values. RAM contents are not touched.

Test Plan (LOG_ADDR_W=3, depth 8, DROP_CNT_W=4):
- Basic logging: reset, log_en=1, 5 consecutive entry_val with data 0x10..0x14 -> writes to addr 0..4 with matching data on the same cycle; curr_log_wr_addr=5, has_wrapped=0.
- Circular wrap (stop_on_wrap=0): 10 entries 0xA0..0xA9 -> the 9th write (0xA8) goes to addr 0; has_wrapped goes to 1 the cycle after the 8th write; final curr_log_wr_addr=2; halted stays 0.
- Stop on wrap (stop_on_wrap=1): 8 entries -> halted=1 after the 8th write (addr 7) and curr_log_wr_addr=0; then 20 entry_val cycles -> no log_wr_req_val and drop_cnt saturates at 15.
- Clear sweep: from the halted state, pulse log_clear -> clear_busy=1 for exactly 8 cycles, writing 0 to addr 0..7 in order; then IDLE with drop_cnt=0, has_wrapped=0, curr_log_wr_addr=0.
- Clear restart: pulse log_clear, then pulse it again on sweep cycle 3 -> addresses written are 0,1,2,0,1,...,7 and clear_busy totals 11 cycles.
- Enable gating: log_en=0 with entry_val -> no write and no drop count; entry_val on the same cycle log_en falls -> ignored; drop_cnt unchanged.
